// File: rtl/cache_sys_pkg.sv
// Shared encodings for the cache memory subsystem: arbiter FSM states,
// transaction op codes and the requester ID type.
package cache_sys_pkg;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WRITE   = 2'd1;
  localparam logic [1:0] READ    = 2'd2;
  localparam logic [1:0] RD_WAIT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = IDLE,
    ST_WRITE   = WRITE,
    ST_READ    = READ,
    ST_RD_WAIT = RD_WAIT
  } state_t;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  localparam int unsigned ID_W = 1;
  typedef logic [ID_W-1:0] req_id_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the
// requester that was not granted last.
module rr_arbiter_2
  import cache_sys_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    last_gnt,
  output logic       gnt_valid,
  output req_id_t    gnt_id
);

  always_comb begin
    gnt_valid = |req;
    gnt_id    = req_id_t'(0);
    if (req == 2'b11) begin
      gnt_id = ~last_gnt;
    end else if (req[1]) begin
      gnt_id = req_id_t'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between two cache requesters: round-robin
// grant, one RAM transaction at a time, read data routed back to its owner.
module mem_port_arbiter
  import cache_sys_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned AWIDTH = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              r0_rden,
  input  logic              r1_rden,
  input  logic              r0_wren,
  input  logic              r1_wren,
  input  logic [WIDTH-1:0]  r0_rdaddr,
  input  logic [WIDTH-1:0]  r1_rdaddr,
  input  logic [WIDTH-1:0]  r0_wraddr,
  input  logic [WIDTH-1:0]  r1_wraddr,
  input  logic [WIDTH-1:0]  r0_wdata,
  input  logic [WIDTH-1:0]  r1_wdata,
  output logic              r0_ack,
  output logic              r1_ack,
  output logic [WIDTH-1:0]  r0_q,
  output logic [WIDTH-1:0]  r1_q,
  output logic              r0_rvalid,
  output logic              r1_rvalid,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [WIDTH-1:0]  ram_din,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [WIDTH-1:0]  ram_dout,
  input  logic              ram_valid
);

  state_t             state_q, state_d;
  req_id_t            owner_q, owner_d;
  req_id_t            last_gnt_q, last_gnt_d;
  logic [AWIDTH-1:0]  addr_q, addr_d;
  logic [WIDTH-1:0]   wdata_q, wdata_d;
  logic [1:0]         ack_q, ack_d;
  logic [1:0]         rvalid_q, rvalid_d;
  logic [WIDTH-1:0]   q0_q, q0_d;
  logic [WIDTH-1:0]   q1_q, q1_d;
  logic               we_q, we_d;
  logic               re_q, re_d;

  logic               gnt_valid;
  req_id_t            gnt_id;
  logic               sel_wren;
  logic               sel_op;
  logic [WIDTH-1:0]   sel_rdaddr;
  logic [WIDTH-1:0]   sel_wraddr;
  logic [WIDTH-1:0]   sel_wdata;

  rr_arbiter_2 u_rr (
    .req       ({r1_rden | r1_wren, r0_rden | r0_wren}),
    .last_gnt  (last_gnt_q),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // Upper requester address bits are dropped on purpose.
  if (WIDTH > AWIDTH) begin : g_addr_trunc
    logic unused_addr_hi;
    assign unused_addr_hi = ^{r0_rdaddr[WIDTH-1:AWIDTH], r0_wraddr[WIDTH-1:AWIDTH],
                              r1_rdaddr[WIDTH-1:AWIDTH], r1_wraddr[WIDTH-1:AWIDTH]};
  end

  // Fields of the granted requester; a write-back wins over its fetch.
  always_comb begin
    sel_wren   = r0_wren;
    sel_rdaddr = r0_rdaddr;
    sel_wraddr = r0_wraddr;
    sel_wdata  = r0_wdata;
    if (gnt_id == req_id_t'(1)) begin
      sel_wren   = r1_wren;
      sel_rdaddr = r1_rdaddr;
      sel_wraddr = r1_wraddr;
      sel_wdata  = r1_wdata;
    end
    sel_op = sel_wren ? OP_WR : OP_RD;
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_gnt_d = last_gnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    q0_d       = q0_q;
    q1_d       = q1_q;
    ack_d      = 2'b00;
    rvalid_d   = 2'b00;
    we_d       = 1'b0;
    re_d       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          owner_d        = gnt_id;
          last_gnt_d     = gnt_id;
          addr_d         = (sel_op == OP_WR) ? sel_wraddr[AWIDTH-1:0] : sel_rdaddr[AWIDTH-1:0];
          wdata_d        = sel_wdata;
          ack_d[gnt_id]  = 1'b1;
          if (sel_op == OP_WR) begin
            state_d = ST_WRITE;
            we_d    = 1'b1;
          end else begin
            state_d = ST_READ;
            re_d    = 1'b1;
          end
        end
      end
      ST_WRITE: state_d = ST_IDLE;
      ST_READ:  state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (ram_valid) begin
          rvalid_d[owner_q] = 1'b1;
          if (owner_q == req_id_t'(1)) q1_d = ram_dout;
          else                         q0_d = ram_dout;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= req_id_t'(0);
      last_gnt_q <= req_id_t'(1);
      addr_q     <= '0;
      wdata_q    <= '0;
      q0_q       <= '0;
      q1_q       <= '0;
      ack_q      <= 2'b00;
      rvalid_q   <= 2'b00;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_gnt_q <= last_gnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      q0_q       <= q0_d;
      q1_q       <= q1_d;
      ack_q      <= ack_d;
      rvalid_q   <= rvalid_d;
      we_q       <= we_d;
      re_q       <= re_d;
    end
  end

  assign r0_ack    = ack_q[0];
  assign r1_ack    = ack_q[1];
  assign r0_rvalid = rvalid_q[0];
  assign r1_rvalid = rvalid_q[1];
  assign r0_q      = q0_q;
  assign r1_q      = q1_q;
  assign ram_addr  = addr_q;
  assign ram_din   = wdata_q;
  assign ram_we    = we_q;
  assign ram_re    = re_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural one-cycle-latency RAM.
module tb_mem_port_arbiter;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned AWIDTH = 16;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              r0_rden, r1_rden, r0_wren, r1_wren;
  logic [WIDTH-1:0]  r0_rdaddr, r1_rdaddr, r0_wraddr, r1_wraddr, r0_wdata, r1_wdata;
  logic              r0_ack, r1_ack, r0_rvalid, r1_rvalid;
  logic [WIDTH-1:0]  r0_q, r1_q;
  logic [AWIDTH-1:0] ram_addr;
  logic [WIDTH-1:0]  ram_din, ram_dout;
  logic              ram_we, ram_re, ram_valid, ram_valid_r, inj_valid;

  logic [WIDTH-1:0]  mem [0:(1<<AWIDTH)-1];

  typedef struct {
    logic              id;
    logic              wr;
    logic [AWIDTH-1:0] addr;
    logic [WIDTH-1:0]  din;
  } ram_exp_t;

  typedef struct {
    logic             id;
    logic [WIDTH-1:0] q;
  } rd_exp_t;

  ram_exp_t ram_exp_q[$];
  rd_exp_t  rd_exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_ack0, t_ack1, t_rv0, t_rv1;
  int hog0 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter #(.WIDTH(WIDTH), .AWIDTH(AWIDTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .r0_rden   (r0_rden),
    .r1_rden   (r1_rden),
    .r0_wren   (r0_wren),
    .r1_wren   (r1_wren),
    .r0_rdaddr (r0_rdaddr),
    .r1_rdaddr (r1_rdaddr),
    .r0_wraddr (r0_wraddr),
    .r1_wraddr (r1_wraddr),
    .r0_wdata  (r0_wdata),
    .r1_wdata  (r1_wdata),
    .r0_ack    (r0_ack),
    .r1_ack    (r1_ack),
    .r0_q      (r0_q),
    .r1_q      (r1_q),
    .r0_rvalid (r0_rvalid),
    .r1_rvalid (r1_rvalid),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_we    (ram_we),
    .ram_re    (ram_re),
    .ram_dout  (ram_dout),
    .ram_valid (ram_valid)
  );

  // RAM: data and valid one cycle after the read strobe
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_valid_r <= 1'b0;
      ram_dout    <= '0;
    end else begin
      ram_valid_r <= ram_re;
      if (ram_re) ram_dout <= mem[ram_addr];
      if (ram_we) mem[ram_addr] <= ram_din;
    end
  end
  assign ram_valid = ram_valid_r | inj_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ram(input logic id, input logic wr, input logic [AWIDTH-1:0] addr,
                          input logic [WIDTH-1:0] din);
    ram_exp_t e;
    e.id = id; e.wr = wr; e.addr = addr; e.din = din;
    ram_exp_q.push_back(e);
  endtask

  task automatic push_rd(input logic id, input logic [WIDTH-1:0] q);
    rd_exp_t e;
    e.id = id; e.q = q;
    rd_exp_q.push_back(e);
  endtask

  // Monitor: every RAM issue and every read return is matched against the scoreboard
  initial begin : monitor
    ram_exp_t e;
    rd_exp_t  r;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1) begin
        if (ram_we || ram_re || r0_ack || r1_ack) begin
          if (ram_exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_issue actual we=%b re=%b ack=%b%b required none", ram_we, ram_re, r1_ack, r0_ack);
          end else begin
            e = ram_exp_q.pop_front();
            chk("issue_op", 32'({ram_we, ram_re}), e.wr ? 32'd2 : 32'd1);
            chk("issue_ack", 32'({r1_ack, r0_ack}), e.id ? 32'd2 : 32'd1);
            chk("issue_addr", 32'(ram_addr), 32'(e.addr));
            if (e.wr) chk("issue_din", ram_din, e.din);
          end
        end
        if (r0_rvalid || r1_rvalid) begin
          if (rd_exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_rvalid actual rvalid=%b%b required none", r1_rvalid, r0_rvalid);
          end else begin
            r = rd_exp_q.pop_front();
            chk("rvalid_owner", 32'({r1_rvalid, r0_rvalid}), r.id ? 32'd2 : 32'd1);
            chk("rdata", r.id ? r1_q : r0_q, r.q);
          end
        end
      end
    end
  end

  // One cycle of requester behaviour: drop the acked op (write first), log event times
  task automatic step();
    @(negedge clk);
    if (r0_ack) begin
      t_ack0 = cyc;
      if (hog0 > 0) hog0--;
      else if (r0_wren) r0_wren = 1'b0;
      else r0_rden = 1'b0;
    end
    if (r1_ack) begin
      t_ack1 = cyc;
      if (r1_wren) r1_wren = 1'b0;
      else r1_rden = 1'b0;
    end
    if (r0_rvalid) t_rv0 = cyc;
    if (r1_rvalid) t_rv1 = cyc;
  endtask

  function automatic logic busy();
    return r0_rden | r0_wren | r1_rden | r1_wren |
           (ram_exp_q.size() != 0) | (rd_exp_q.size() != 0);
  endfunction

  task automatic run(input string name, input int budget);
    int n = 0;
    while (busy() && n < budget) begin
      step();
      n++;
    end
    chk({name, "_drained"}, 32'(busy()), 32'd0);
    step();
    step();
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ack"}, 32'({r1_ack, r0_ack}), 32'd0);
    chk({tag, "_rvalid"}, 32'({r1_rvalid, r0_rvalid}), 32'd0);
    chk({tag, "_q0"}, r0_q, 32'd0);
    chk({tag, "_q1"}, r1_q, 32'd0);
    chk({tag, "_ram_ctl"}, 32'({ram_we, ram_re}), 32'd0);
    chk({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
    chk({tag, "_ram_din"}, ram_din, 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin : stim
    int t;
    r0_rden = 0; r1_rden = 0; r0_wren = 0; r1_wren = 0;
    r0_rdaddr = '0; r1_rdaddr = '0; r0_wraddr = '0; r1_wraddr = '0;
    r0_wdata = '0; r1_wdata = '0; inj_valid = 1'b0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    reset_n = 1'b1;
    step();

    // Single write by r0, then r1 reads it back
    push_ram(1'b0, 1'b1, 16'h0004, 32'hDEADBEEF);
    r0_wraddr = 32'h0000_0004; r0_wdata = 32'hDEADBEEF; r0_wren = 1'b1;
    t = cyc;
    run("wr", 20);
    chk("wr_ack_latency", 32'(t_ack0 - t), 32'd1);
    push_ram(1'b1, 1'b0, 16'h0004, 32'h0);
    push_rd(1'b1, 32'hDEADBEEF);
    r1_rdaddr = 32'h0000_0004; r1_rden = 1'b1;
    t = cyc;
    run("rd", 20);
    chk("rd_ack_latency", 32'(t_ack1 - t), 32'd1);
    chk("rd_rvalid_latency", 32'(t_rv1 - t), 32'd3);

    // Write-back then fetch from r0
    push_ram(1'b0, 1'b1, 16'h0030, 32'hCAFE0030);
    push_ram(1'b0, 1'b0, 16'h0004, 32'h0);
    push_rd(1'b0, 32'hDEADBEEF);
    r0_wraddr = 32'h30; r0_wdata = 32'hCAFE0030; r0_rdaddr = 32'h4;
    r0_wren = 1'b1; r0_rden = 1'b1;
    t = cyc;
    run("wb_fetch", 30);
    chk("wb_fetch_rd_ack", 32'(t_ack0 - t), 32'd3);
    chk("wb_fetch_rvalid", 32'(t_rv0 - t), 32'd5);

    // Preload two words, r0 then r1, so r1 holds last grant
    push_ram(1'b0, 1'b1, 16'h0010, 32'hA5A50010);
    r0_wraddr = 32'h10; r0_wdata = 32'hA5A50010; r0_wren = 1'b1;
    run("pre0", 20);
    push_ram(1'b1, 1'b1, 16'h0020, 32'h5A5A0020);
    r1_wraddr = 32'h20; r1_wdata = 32'h5A5A0020; r1_wren = 1'b1;
    run("pre1", 20);

    // Simultaneous reads
    push_ram(1'b0, 1'b0, 16'h0010, 32'h0);
    push_ram(1'b1, 1'b0, 16'h0020, 32'h0);
    push_rd(1'b0, 32'hA5A50010);
    push_rd(1'b1, 32'h5A5A0020);
    r0_rdaddr = 32'h10; r1_rdaddr = 32'h20; r0_rden = 1'b1; r1_rden = 1'b1;
    t = cyc;
    run("dual_rd", 30);
    chk("dual_ack0", 32'(t_ack0 - t), 32'd1);
    chk("dual_rv0", 32'(t_rv0 - t), 32'd3);
    chk("dual_ack1", 32'(t_ack1 - t), 32'd4);
    chk("dual_rv1", 32'(t_rv1 - t), 32'd6);

    // Stray ram_valid while idle must not touch q or rvalid
    inj_valid = 1'b1;
    step();
    inj_valid = 1'b0;
    step();
    step();
    chk("stray_valid_q0", r0_q, 32'hA5A50010);
    chk("stray_valid_q1", r1_q, 32'h5A5A0020);

    // Both requesters write and read together: 0W, 1W, 0R, 1R
    push_ram(1'b0, 1'b1, 16'h0040, 32'h40404040);
    push_ram(1'b1, 1'b1, 16'h0050, 32'h50505050);
    push_ram(1'b0, 1'b0, 16'h0030, 32'h0);
    push_ram(1'b1, 1'b0, 16'h0040, 32'h0);
    push_rd(1'b0, 32'hCAFE0030);
    push_rd(1'b1, 32'h40404040);
    r0_wraddr = 32'h40; r0_wdata = 32'h40404040; r0_rdaddr = 32'h30;
    r1_wraddr = 32'h50; r1_wdata = 32'h50505050; r1_rdaddr = 32'h40;
    r0_wren = 1'b1; r0_rden = 1'b1; r1_wren = 1'b1; r1_rden = 1'b1;
    t = cyc;
    run("quad", 40);
    chk("quad_rv1_latency", 32'(t_rv1 - t), 32'd10);

    // Fairness: r0 keeps writing, r1 slips one read in between
    push_ram(1'b0, 1'b1, 16'h0060, 32'h66666666);
    push_ram(1'b1, 1'b0, 16'h0050, 32'h0);
    push_ram(1'b0, 1'b1, 16'h0060, 32'h66666666);
    push_rd(1'b1, 32'h50505050);
    r0_wraddr = 32'h60; r0_wdata = 32'h66666666; r0_wren = 1'b1; hog0 = 1;
    t = cyc;
    step();
    r1_rdaddr = 32'h50; r1_rden = 1'b1;
    begin
      int t1;
      t1 = cyc;
      run("fair", 30);
      chk("fair_r1_ack_latency", 32'(t_ack1 - t1), 32'd2);
    end
    chk("fair_r0_second_ack", 32'(t_ack0 - t), 32'd6);

    // Upper address bits are discarded
    push_ram(1'b1, 1'b0, 16'h0010, 32'h0);
    push_rd(1'b1, 32'hA5A50010);
    r1_rdaddr = 32'hFFFF_0010; r1_rden = 1'b1;
    run("trunc", 20);

    // Reset while waiting for read data
    push_ram(1'b0, 1'b0, 16'h0010, 32'h0);
    r0_rdaddr = 32'h10; r0_rden = 1'b1;
    step();
    step();
    reset_n = 1'b0;
    r0_rden = 1'b0;
    #1;
    chk_idle_outputs("midrd_reset");
    chk("midrd_issue_seen", 32'(ram_exp_q.size()), 32'd0);
    step();
    step();
    reset_n = 1'b1;
    step();
    step();
    step();

    // First tie after reset goes to r0
    push_ram(1'b0, 1'b0, 16'h0020, 32'h0);
    push_ram(1'b1, 1'b0, 16'h0030, 32'h0);
    push_rd(1'b0, 32'h5A5A0020);
    push_rd(1'b1, 32'hCAFE0030);
    r0_rdaddr = 32'h20; r1_rdaddr = 32'h30; r0_rden = 1'b1; r1_rden = 1'b1;
    t = cyc;
    run("post_reset_tie", 30);
    chk("post_reset_rv0", 32'(t_rv0 - t), 32'd3);
    chk("post_reset_rv1", 32'(t_rv1 - t), 32'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port backing `Ram` between two cache memory interfaces, for example an I-cache and a D-cache, each with its own miss/write-back port. It arbitrates round-robin between requesters and serialises each transaction onto the RAM's one address bus. Read data is routed back to the owning requester with a valid pulse. Only one RAM transaction is outstanding at any time.

## Interface
Parameters:
- `WIDTH`, 32: data width and requester address width.
- `AWIDTH`, 16: RAM address width; equals the RAM `DEPTH` parameter.

Ports:
- `clk` in 1: clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `r0_rden`, `r1_rden` in 1: read request, level, held until ack.
- `r0_wren`, `r1_wren` in 1: write request, level, held until ack.
- `r0_rdaddr`, `r1_rdaddr` in WIDTH: read address.
- `r0_wraddr`, `r1_wraddr` in WIDTH: write address.
- `r0_wdata`, `r1_wdata` in WIDTH: write data.
- `r0_ack`, `r1_ack` out 1: one-cycle pulse; the request was issued to the RAM.
- `r0_q`, `r1_q` out WIDTH: returned read data, held until that requester's next read completes.
- `r0_rvalid`, `r1_rvalid` out 1: one-cycle pulse; `rN_q` is valid.
- `ram_addr` out AWIDTH: RAM address.
- `ram_din` out WIDTH: RAM write data.
- `ram_we` out 1: RAM write enable.
- `ram_re` out 1: RAM read enable.
- `ram_dout` in WIDTH: RAM `data_out`.
- `ram_valid` in 1: RAM `valid_out`.

## Operation
- **States:** IDLE, WRITE, READ, RD_WAIT.
- **IDLE, arbitration:**
  - A requester is pending if it asserts `rden` or `wren`.
  - If one requester is pending, it is granted.
  - If both are pending, grant the one that is not `last_gnt`.
  - `last_gnt` resets to 1, so requester 0 wins the first tie.
  - On grant, latch the owner ID, the op, `addr[AWIDTH-1:0]` and `wdata`, then set `last_gnt` to the owner.
- **Op selection within a requester:** `wren` has priority over `rden`, so a write-back is issued before its fetch. The read needs a separate, later grant.
- **Next state from IDLE:** WRITE for a write grant, READ for a read grant. With no request, stay in IDLE.
- **WRITE:**
  - Drive `ram_we`=1 with the latched addr/data.
  - Pulse `ack` to the owner.
  - Go to IDLE.
- **READ:**
  - Drive `ram_re`=1 with the latched addr.
  - Pulse `ack` to the owner.
  - Go to RD_WAIT.
- **RD_WAIT:**
  - On `ram_valid`, register `ram_dout` into the owner's `q` and set the owner's `rvalid` for the next cycle. Go to IDLE.
  - Without `ram_valid`, stay in RD_WAIT.
- **Address width:** the upper `WIDTH-AWIDTH` address bits are discarded; no error is raised.
- **RAM outputs outside WRITE/READ:** `ram_we`=`ram_re`=0. `ram_addr` and `ram_din` hold their last latched value.
- **Boundary conditions:**
  - `ram_valid` while not in RD_WAIT is ignored.
  - A requester that drops its request before ack is not serviced. Requesters must not drop early; this is a protocol violation.
  - A requester can be granted again immediately after its own ack only if the other requester is idle.
  - Simultaneous `rden` and `wren` from both requesters: four serialised grants in the order 0W, 1W, 0R, 1R.
- **Reset:**
  - All outputs reset to 0, state to IDLE, `last_gnt` to 1.
  - Reset mid-transaction aborts the transaction with no ack and no rvalid. The RAM is reset by the same `reset_n`.

## Timing
- Request first seen in IDLE at cycle t.
- Write:
  - cycle t+1: `ram_we`=1 and `ack`=1.
  - cycle t+2: IDLE again; arbitration resumes.
- Read:
  - cycle t+1: `ram_re`=1 and `ack`=1.
  - cycle t+2: `ram_valid`=1.
  - cycle t+3: `rvalid`=1 with `q`. The state is IDLE in this same cycle and may grant a new request.
- Throughput: one write per 2 cycles, one read per 3 cycles.
- Starvation bound: a pending requester is acked within at most 4 cycles while the other requester hogs the port.
- `ack` and `rvalid` are registered. `ram_*` outputs are decoded from the state register plus latched fields, with no combinational path from requester inputs.

## Structure
- Shared package `cache_sys_pkg` holds:
  - state encoding localparams: IDLE=2'd0, WRITE=2'd1, READ=2'd2, RD_WAIT=2'd3;
  - op encoding: OP_RD=0, OP_WR=1;
  - requester ID width = 1.
- Sub-module `rr_arbiter_2`: combinational 2-way round-robin pick.
  - Inputs: `req[1:0]`, `last_gnt`.
  - Outputs: `gnt_valid`, `gnt_id`.
- FSM, latches and return routing live in `mem_port_arbiter`.

## Test plan
- **Single write:** r0 writes addr 0x0004 with data 0xDEADBEEF → `ram_we` for 1 cycle at t+1 with `ram_addr`=0x0004, `r0_ack` at t+1. A subsequent r1 read of 0x0004 gives `r1_q`=0xDEADBEEF with `r1_rvalid` at t+3.
- **Simultaneous reads:** both requesters read at t0 → r0 is served first (`r0_rvalid` at t0+3), r1 second (`r1_ack` at t0+4, `r1_rvalid` at t0+6). `last_gnt`=1 afterwards.
- **Write-back then fetch:** r0 asserts `wren` and `rden` together → write acked first, read issued next. `r0_q` returns the fetched data, never the written data unless the addresses are equal.
- **Fairness:** r0 requests continuously while r1 requests once → r1 is acked within 4 cycles of its request, and grants alternate while both are pending.
- **Address truncation:** r1 reads 0xFFFF_0010 → `ram_addr`=0x0010.
- **Reset mid-read:** `reset_n` low during RD_WAIT → no `rvalid`, all outputs 0, state IDLE. The first post-reset tie goes to r0.
